flush_ctrl_pipe: RTL and testbench

- Parametrised, registered successor to the combinational ID-stage control squash used for J/JR/BNE.
- Carries the decoded control bundle from ID through STAGES pipeline registers (ID/EX onward).
- Zeroes (squashes) the bundle for a programmable window of FLUSH_CYCLES issue slots after a flush request, and inserts bubbles on load-use stalls.
- Tracks valid bits per stage and keeps a saturating count of squashed real instructions for performance debug.

---
 rtl/flush_ctrl_pipe.sv | 93 +++++++++
 tb/tb_flush_ctrl_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/flush_ctrl_pipe.sv
// Registered ID/EX-onward control pipeline with a programmable post-branch squash window,
// load-use bubble insertion, per-stage valid tracking and a saturating squash counter.
module flush_ctrl_pipe #(
    parameter int CTRL_W       = 11,
    parameter int STAGES       = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush_req,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [STAGES-1:0] valid_out,
    output logic              flush_active,
    output logic [CNT_W-1:0]  squash_count
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("flush_ctrl_pipe: STAGES must be in 1..4");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
        $error("flush_ctrl_pipe: FLUSH_CYCLES must be in 1..7");
    end

    localparam logic [2:0]       WIN_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [2:0]        win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              valid_d;
    logic              squash;

    assign squash = flush_req | (win_cnt_q != 3'd0);

    // flush_req is a raw input, so it is masked to keep every output at 0 while reset is held.
    assign flush_active = squash & ~reset;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        ctrl_d    = '0;
        valid_d   = 1'b0;
        win_cnt_d = win_cnt_q;
        count_d   = count_q;

        if (!squash && !stall) begin
            ctrl_d  = ctrl_in & {CTRL_W{valid_in}};
            valid_d = valid_in;
        end

        // A flush restarts the window even while stalled; otherwise a stall freezes it.
        if (flush_req) begin
            win_cnt_d = WIN_LOAD;
        end else if (!stall && win_cnt_q != 3'd0) begin
            win_cnt_d = win_cnt_q - 3'd1;
        end

        if (squash && valid_in && !stall && count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the stage shift reads pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                ctrl_q[i] <= '0;
            end
            valid_q   <= '0;
            win_cnt_q <= 3'd0;
            count_q   <= '0;
        end else begin
            ctrl_q[0]  <= ctrl_d;
            valid_q[0] <= valid_d;
            for (int i = 1; i < STAGES; i++) begin
                ctrl_q[i]  <= ctrl_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
            win_cnt_q <= win_cnt_d;
            count_q   <= count_d;
        end
    end

    assign ctrl_out     = ctrl_q[STAGES-1];
    assign valid_out    = valid_q;
    assign squash_count = count_q;

endmodule

// File: tb/tb_flush_ctrl_pipe.sv
// Scoreboard bench for flush_ctrl_pipe: directed plan sequences plus random traffic, checked
// against a slot-queue reference model of the squash/stall rules.
module tb_flush_ctrl_pipe;

    localparam int CTRL_W       = 11;
    localparam int STAGES       = 2;
    localparam int FLUSH_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic [CTRL_W-1:0] ctrl_in;
    logic              valid_in;
    logic              stall;
    logic              flush_req;
    logic [CTRL_W-1:0] ctrl_out;
    logic [STAGES-1:0] valid_out;
    logic              flush_active;
    logic [CNT_W-1:0]  squash_count;

    flush_ctrl_pipe #(
        .CTRL_W      (CTRL_W),
        .STAGES      (STAGES),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_in     (ctrl_in),
        .valid_in    (valid_in),
        .stall       (stall),
        .flush_req   (flush_req),
        .ctrl_out    (ctrl_out),
        .valid_out   (valid_out),
        .flush_active(flush_active),
        .squash_count(squash_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [STAGES-1:0] valid;
        logic              fa;
        logic [CNT_W-1:0]  cnt;
    } snap_t;

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic              v;
    } slot_t;

    snap_t exp_q[$];
    slot_t m_pipe[$];
    int    m_left;
    int    m_cnt;
    int    n_compared;
    int    n_mismatched;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot_t z;
        z.c = '0;
        z.v = 1'b0;
        m_pipe.delete();
        for (int i = 0; i < STAGES; i++) m_pipe.push_back(z);
        m_left = 0;
        m_cnt  = 0;
    endtask

    // One issue slot: drive inputs just after the edge, record what the outputs must show
    // before the next edge, then advance the model across that edge.
    task automatic do_cycle(input logic r, input logic [CTRL_W-1:0] c, input logic v,
                            input logic st, input logic fl);
        snap_t s;
        slot_t n;
        logic  sq;
        @(posedge clk);
        #1;
        reset     = r;
        ctrl_in   = c;
        valid_in  = v;
        stall     = st;
        flush_req = fl;
        if (r) model_reset();
        s.ctrl = m_pipe[STAGES-1].c;
        for (int i = 0; i < STAGES; i++) s.valid[i] = m_pipe[i].v;
        s.fa  = !r && (fl || m_left > 0);
        s.cnt = CNT_W'(m_cnt);
        exp_q.push_back(s);
        if (!r) begin
            sq  = fl || (m_left > 0);
            n.v = !(sq || st) && v;
            n.c = n.v ? c : '0;
            m_pipe.push_front(n);
            void'(m_pipe.pop_back());
            if (sq && v && !st && m_cnt < CNT_MAX) m_cnt++;
            if (fl) m_left = FLUSH_CYCLES - 1;
            else if (!st && m_left > 0) m_left--;
        end
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("ctrl_out",     32'(ctrl_out),     32'(s.ctrl));
                check("valid_out",    32'(valid_out),    32'(s.valid));
                check("flush_active", 32'(flush_active), 32'(s.fa));
                check("squash_count", 32'(squash_count), 32'(s.cnt));
            end
        end
    end

    initial begin : stimulus
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b1;
        ctrl_in   = '0;
        valid_in  = 1'b0;
        stall     = 1'b0;
        flush_req = 1'b0;
        model_reset();

        // Reset held two cycles, with a flush request that must stay invisible.
        do_cycle(1'b1, 11'h2A5, 1'b1, 1'b0, 1'b1);
        do_cycle(1'b1, 11'h2A5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 11'h2A5, 1'b1, 1'b0, 1'b0);

        // Single flush on a full-ones bundle, then a clean stream.
        do_cycle(1'b0, 11'h7FF, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 11'h155, 1'b1, 1'b0, 1'b0);

        // Flush followed by a two-cycle stall inside the window.
        do_cycle(1'b0, 11'h155, 1'b1, 1'b0, 1'b1);
        do_cycle(1'b0, 11'h155, 1'b1, 1'b1, 1'b0);
        do_cycle(1'b0, 11'h155, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 11'h0AA, 1'b1, 1'b0, 1'b0);

        // Flush and stall together, then invalid slots carrying nonzero control.
        do_cycle(1'b0, 11'h3C3, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 11'h3C3, 1'b0, 1'b0, 1'b0);

        // Saturation: twenty back-to-back flushes of valid instructions.
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 11'h111, 1'b1, 1'b0, 1'b1);
        do_cycle(1'b0, 11'h222, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of an open window; nothing squashes afterwards.
        do_cycle(1'b1, 11'h222, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 11'h333, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 99) == 0),
                     CTRL_W'($urandom),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
